// File: rtl/core_seq_r32i.sv
// core_seq_r32i: multi-cycle RV32I sequencer.
// It steps each instruction through FETCH, DECODE, EXEC, an optional MEM and
// WB. It handshakes with the instruction and data memories and keeps the PC,
// the instruction register and the cycle and retire counters.
// If a memory wait runs too long, or the decoder flags an illegal opcode,
// the core halts in TRAP until reset.
module core_seq_r32i #(
  parameter int               dataW    = 32,
  parameter logic [dataW-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [dataW-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [dataW-1:0] imem_rdata,
  output logic [dataW-1:0] ins_out,
  input  logic             reg_write_ctl,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             illegal,
  input  logic [dataW-1:0] pc_next,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             reg_we,
  output logic [dataW-1:0] pc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [dataW-1:0] cycle_cnt,
  output logic [dataW-1:0] instret_cnt
);

  // The wait counter only has to reach TIMEOUT-1. The TIMEOUT-th unanswered
  // cycle is the one that is checked against that last value.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t            state_q,   state_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic [dataW-1:0]  pc_q,      pc_d;
  logic [dataW-1:0]  ir_q,      ir_d;
  logic [1:0]        cause_q,   cause_d;
  logic [dataW-1:0]  cycle_q,   cycle_d;
  logic [dataW-1:0]  instret_q, instret_d;

  // State register. Reset lands in FETCH with everything cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cause_q   <= 2'd0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Next-state sequencing. In FETCH and MEM an ack is tested before the
  // timeout, so an ack on the final allowed cycle is still accepted.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    cycle_d   = (state_q == S_TRAP) ? cycle_q : cycle_q + dataW'(1);
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        pc_d      = pc_next;
        instret_d = instret_q + dataW'(1);
        wait_d    = '0;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes decode straight from the state, so at most one is high at a
  // time. They are also gated by reset, because reset parks the state in
  // FETCH and would otherwise raise imem_req while reset is still held.
  assign imem_req    = !reset && (state_q == S_FETCH);
  assign dmem_req    = !reset && (state_q == S_MEM);
  assign dmem_we     = dmem_req && is_store;
  assign reg_we      = !reset && (state_q == S_WB) && reg_write_ctl;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ins_out     = ir_q;
  assign trap        = (state_q == S_TRAP);
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
